// File: rtl/hw_int_ctrl.sv
// Six-source interrupt controller feeding CP0 HWInt[7:2]: latch, mask, prioritise, hold in service until EOI.
// Optional INT_COUNT_EN adds a saturating 16-bit acknowledge counter readable in STAT[31:16].
module hw_int_ctrl #(
  parameter int NSRC = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic            intAck,
  input  logic            we,
  input  logic [1:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [NSRC-1:0] HWInt
);

  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} stateT;

  stateT           state, stateNext;
  logic [NSRC-1:0] mask, mode, edgePend, srcQ;
  logic [NSRC-1:0] maskNext, modeNext, edgePendNext;
  logic [NSRC-1:0] pend, req, reqOneHot, clrBits;
  logic [2:0]      id, reqId;
  logic            busy;
  logic            wrMask, wrMode, wrPend, wrStat, ackTake;
  logic [15:0]     cntRd;
  logic            unusedWdata;

  assign unusedWdata = ^wdata[31:NSRC];

  assign wrMask = we && (addr == 2'd0);
  assign wrMode = we && (addr == 2'd1);
  assign wrPend = we && (addr == 2'd2);
  assign wrStat = we && (addr == 2'd3);

  // Level sources read straight through src_q; only edge sources keep latched state.
  assign pend      = (edgePend & mode) | (srcQ & ~mode);
  assign req       = pend & mask;
  assign reqOneHot = req & (~req + 1'b1);

  always_comb begin
    reqId = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) reqId = 3'(i);
    end
  end

  // intAck is a one-cycle commit strobe from CP0; it is honoured only while a request is shown.
  assign ackTake = (state == ASSERT) && intAck && (req != '0);

  assign maskNext = wrMask ? wdata[NSRC-1:0] : mask;
  assign modeNext = wrMode ? wdata[NSRC-1:0] : mode;

  always_comb begin
    clrBits = '0;
    if (wrPend)  clrBits = clrBits | (wdata[NSRC-1:0] & mode);
    if (ackTake) clrBits = clrBits | (reqOneHot & mode);
  end

  // New edges win over clears; a source switched to level drops its latched edge.
  assign edgePendNext = ((edgePend & ~clrBits) | (src & ~srcQ)) & modeNext;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (req != '0) stateNext = ASSERT;
      ASSERT: begin
        if (req == '0)  stateNext = IDLE;
        else if (intAck) stateNext = SERVICE;
      end
      SERVICE: if (wrStat) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign HWInt = (state == ASSERT) ? reqOneHot : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mask     <= '0;
      mode     <= '0;
      edgePend <= '0;
      srcQ     <= '0;
      id       <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= stateNext;
      mask     <= maskNext;
      mode     <= modeNext;
      edgePend <= edgePendNext;
      srcQ     <= src;
      if (ackTake) begin
        id   <= reqId;
        busy <= 1'b1;
      end else if ((state == SERVICE) && wrStat) begin
        busy <= 1'b0;
      end
    end
  end

`ifdef INT_COUNT_EN
  logic [15:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (ackTake && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign cntRd = cnt;
`else
  assign cntRd = '0;
`endif

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0: rdata = {{(32 - NSRC){1'b0}}, mask};
      2'd1: rdata = {{(32 - NSRC){1'b0}}, mode};
      2'd2: rdata = {{(32 - NSRC){1'b0}}, pend};
      2'd3: rdata = {cntRd, 8'b0, busy, 4'b0, id};
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_hw_int_ctrl.sv
// Bench for hw_int_ctrl: directed scenarios then random traffic, checked against a cycle-level model.
// Build with or without INT_COUNT_EN; the model follows the same define.
module tb_hw_int_ctrl;

`ifdef INT_COUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [5:0]  src;
  logic        intAck;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [5:0]  HWInt;

  int errors = 0;
  int checks = 0;

  hw_int_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .src    (src),
    .intAck (intAck),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .HWInt  (HWInt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference model: phase 0 = nothing shown, 1 = request shown, 2 = in service.
  logic [5:0]  m_mask, m_mode, m_epend, m_srcq;
  int          m_phase;
  int          m_id;
  logic [15:0] m_cnt;

  function automatic logic [5:0] m_req();
    return ((m_epend & m_mode) | (m_srcq & ~m_mode)) & m_mask;
  endfunction

  function automatic int first_idx(input logic [5:0] v);
    for (int i = 0; i < 6; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] exp_rd(input int a);
    logic [31:0] r;
    case (a)
      0: r = {26'b0, m_mask};
      1: r = {26'b0, m_mode};
      2: r = {26'b0, (m_epend & m_mode) | (m_srcq & ~m_mode)};
      default: r = {m_cnt, 8'b0, (m_phase == 2), 4'b0, 3'(m_id)};
    endcase
    return r;
  endfunction

  function automatic logic [5:0] exp_hw();
    logic [5:0] r;
    r = m_req();
    if (m_phase != 1 || r == 6'b0) return 6'b0;
    return 6'(1 << first_idx(r));
  endfunction

  task automatic model_reset();
    m_mask = '0; m_mode = '0; m_epend = '0; m_srcq = '0;
    m_phase = 0; m_id = 0; m_cnt = '0;
  endtask

  task automatic model_step();
    logic [5:0] r, nmask, nmode, clr;
    r = m_req();
    nmask = m_mask;
    nmode = m_mode;
    clr = '0;
    if (we && addr == 2'd0) nmask = wdata[5:0];
    if (we && addr == 2'd1) nmode = wdata[5:0];
    if (we && addr == 2'd2) clr = wdata[5:0] & m_mode;
    case (m_phase)
      0: if (r != 0) m_phase = 1;
      1: begin
        if (r == 0) m_phase = 0;
        else if (intAck) begin
          m_phase = 2;
          m_id = first_idx(r);
          if (m_mode[m_id]) clr[m_id] = 1'b1;
          if (CntEn && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
      end
      default: if (we && addr == 2'd3) m_phase = 0;
    endcase
    m_epend = ((m_epend & ~clr) | (src & ~m_srcq)) & nmode;
    m_srcq = src;
    m_mask = nmask;
    m_mode = nmode;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    logic [1:0] saved;
    saved = addr;
    chk("hwint", 32'(HWInt), 32'(exp_hw()));
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      chk($sformatf("rdata%0d", a), rdata, exp_rd(a));
    end
    addr = saved;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset();
    else model_step();
    #1;
    check_all();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0; wdata = '0;
  endtask

  task automatic ack();
    intAck = 1'b1;
    tick();
    intAck = 1'b0;
  endtask

  task automatic pulse(input logic [5:0] s);
    src = s;
    tick();
    src = '0;
    tick();
  endtask

  initial begin
    reset = 1'b0; src = '0; intAck = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    model_reset();
    #1;
    check_all();
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Single edge source, ack, EOI
    wr(2'd0, 32'h3F);
    wr(2'd1, 32'h3F);
    pulse(6'b001000);
    chk("tp1_hwint", 32'(HWInt), 32'h08);
    ack();
    chk("tp1_hwint_svc", 32'(HWInt), 32'h00);
    addr = 2'd3; #1;
    chk("tp1_stat", rdata, CntEn ? 32'h0001_0083 : 32'h0000_0083);
    addr = 2'd2; #1;
    chk("tp1_pend3", 32'(rdata[3]), 32'h0);
    wr(2'd3, 32'h0);
    tick();

    // Two simultaneous edges: priority then the loser after EOI
    pulse(6'b010010);
    chk("tp2_first", 32'(HWInt), 32'h02);
    ack();
    wr(2'd3, 32'h0);
    tick();
    chk("tp2_second", 32'(HWInt), 32'h10);
    ack();
    wr(2'd3, 32'h0);
    tick();

    // Level source held through service
    wr(2'd1, 32'h00);
    src = 6'b000100;
    tick();
    tick();
    chk("tp3_level", 32'(HWInt), 32'h04);
    ack();
    wr(2'd3, 32'h0);
    tick();
    chk("tp3_reassert", 32'(HWInt), 32'h04);
    src = '0;
    tick();
    tick();
    chk("tp3_drop", 32'(HWInt), 32'h00);

    // Preemption and masking while shown
    wr(2'd1, 32'h3F);
    pulse(6'b100000);
    chk("tp4_src5", 32'(HWInt), 32'h20);
    src = 6'b000001;
    tick();
    src = '0;
    chk("tp4_preempt", 32'(HWInt), 32'h01);
    wr(2'd0, 32'h00);
    chk("tp4_masked", 32'(HWInt), 32'h00);
    tick();
    wr(2'd0, 32'h3F);
    tick();
    ack();

    // Asynchronous reset while in service
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_hwint", 32'(HWInt), 32'h0);
    #1;
    reset = 1'b1;
    tick();

    // Three full ack/EOI rounds for the counter
    wr(2'd0, 32'h3F);
    wr(2'd1, 32'h3F);
    for (int k = 0; k < 3; k++) begin
      pulse(6'b000001);
      ack();
      wr(2'd3, 32'h0);
    end
    addr = 2'd3; #1;
    chk("cnt3", 32'(rdata[31:16]), CntEn ? 32'd3 : 32'd0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      src = 6'($urandom_range(0, 63));
      intAck = ($urandom_range(0, 2) == 0);
      we = ($urandom_range(0, 5) == 0);
      addr = 2'($urandom_range(0, 3));
      wdata = $urandom;
      tick();
    end
    we = 1'b0; intAck = 1'b0; src = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hw_int_ctrl.md
# hw_int_ctrl

Interrupt controller that sits between the external device interrupt lines and the CP0 `HWInt[7:2]` input. It latches, masks and prioritises six device sources and presents one request at a time to CP0. It holds that source in service until the handler writes end-of-interrupt over the bridge bus. It is memory-mapped on the bridge, next to the timers.

## Interface
Parameters:
- `NSRC`, 6: number of sources. Fixed to the `HWInt` width; other values are unsupported.

Ports:
- `clk` in 1: system clock. All state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `src` in 6: raw device interrupt lines, synchronous to `clk`. `src[i]` maps to `HWInt[i+2]`.
- `intAck` in 1: high in the cycle CP0 commits an interrupt, i.e. CP0's IntReq term.
- `we` in 1: bridge write strobe.
- `addr` in 2: word offset, i.e. byte address bits [3:2]. Base address is decoded by the bridge.
- `wdata` in 32: bridge write data.
- `rdata` out 32: combinational read data for `addr`.
- `HWInt` out 6: one-hot request to CP0 `HWInt[7:2]`. All-zero when idle.

## Operation
Register map:
- 0 MASK[5:0]: R/W. Bit = 1 enables the source.
- 1 MODE[5:0]: R/W. 1 = edge-triggered, 0 = level.
- 2 PEND[5:0]: read returns pending bits. Write is write-1-to-clear, edge sources only.
- 3 STAT: read `{cnt[15:0] or 0, 8'b0, busy, 4'b0, id[2:0]}`. Any write is EOI.

Unused read bits are 0.

Pending logic:
- `src_q` samples `src` every cycle.
- Edge source: `PEND[i]` set on `src[i] & ~src_q[i]`.
- Level source: `PEND[i]` = `src_q[i]`.
- Set and clear in the same cycle: set wins.
- Changing MODE to level discards any latched edge state for that source.

Request vector `req = PEND & MASK`. Priority: lowest index wins, so `src[0]` has the highest priority.

FSM:
- IDLE → ASSERT when `req != 0`.
- ASSERT:
  - `HWInt = onehot(highest req)`, re-evaluated every cycle, so a newly arriving higher-priority source preempts the one shown.
  - If `req == 0` (cleared or masked): → IDLE, `HWInt` drops.
  - If `intAck`: latch `id = encode(req)`, set busy, clear `PEND[id]` if edge mode, → SERVICE.
- SERVICE:
  - `HWInt = 0`. No nesting.
  - Pending bits continue to accumulate.
  - EOI write: clear busy, → IDLE.
- EOI in IDLE or ASSERT is ignored.
- `intAck` outside ASSERT is ignored.

## Timing
Reset values (asynchronous, immediate):
- State IDLE; MASK, MODE, PEND, `src_q`, id, busy, cnt all 0.
- `HWInt = 0`; `rdata` reflects the zeroed registers.

Latencies:
- Edge on `src` before edge k: PEND set at k, ASSERT at k+1, `HWInt` valid in the cycle after k+1.
- `intAck` sampled at edge n: SERVICE from n, `HWInt` 0 in the cycle after n.
- EOI write at edge m: IDLE at m. If `req` is still nonzero, ASSERT at m+1.

Bus timing:
- Register writes take effect at the edge where `we` is high.
- A W1C and an `intAck` on the same bit at the same edge clear it once; no error.

Reset asserted mid-operation (any state) aborts service. CP0 must be reset in the same event.

## Configuration
- `INT_COUNT_EN` defined: 16-bit counter `cnt` increments on each ASSERT→SERVICE transition and saturates at 16'hFFFF. It appears in STAT[31:16] and is cleared only by reset.
- Undefined: no counter logic; STAT[31:16] reads 0.

## Test plan
- Reset, MASK=6'h3F, MODE=6'h3F, pulse `src[3]` 1 cycle → `HWInt`=6'b001000 two edges later. Assert `intAck` → `HWInt`=0, STAT reads busy=1, id=3, PEND[3]=0. Write STAT → IDLE, `HWInt`=0.
- `src[4]` and `src[1]` pulse together, edge mode → `HWInt`=6'b000010. After `intAck` + EOI → `HWInt`=6'b010000.
- Level source 2, MASK[2]=1, hold `src[2]`=1 through `intAck` + EOI → request reasserts (ASSERT one edge after EOI). Drop `src[2]` → `HWInt`=0 within 2 edges.
- In ASSERT showing source 5, write MASK=0 → `HWInt`=0 next cycle, state IDLE. Also: `src[0]` arriving while source 5 is shown → `HWInt` switches to 6'b000001.
- Mid-SERVICE, drive `reset`=0 asynchronously between edges → `HWInt`, `rdata` fields, busy all 0 immediately, with no clock edge required.
- With `INT_COUNT_EN`: 3 full ack/EOI cycles → STAT[31:16]=16'h0003. Without the macro → 16'h0000.
